dbg_trace_buf: RTL

//  Parametrised successor to the DPI debug probe: a synthesizable commit-trace ring buffer.

---
 rtl/dbg_trace_buf.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dbg_trace_buf.sv
// Commit-trace ring buffer: records one entry per retired instruction,
// freezes capture and requests a core stall on ebreak / invalid instruction,
// and lets a host drain the oldest records over a valid/ready port.
module dbg_trace_buf #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int WRAP_MODE   = 1,
    parameter int HALT_ON_BRK = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     commit_valid,
    input  logic [XLEN-1:0]          commit_pc,
    input  logic [31:0]              commit_inst,
    input  logic                     commit_brk,
    input  logic                     commit_ivd,
    input  logic                     gpr_wen,
    input  logic [4:0]               gpr_waddr,
    input  logic [XLEN-1:0]          gpr_wdata,
    input  logic                     csr_wen,
    input  logic [11:0]              csr_waddr,
    input  logic [XLEN-1:0]          csr_wdata,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [XLEN-1:0]          rd_pc,
    output logic [31:0]              rd_inst,
    output logic [3:0]               rd_flags,
    output logic [4:0]               rd_gpr_waddr,
    output logic [XLEN-1:0]          rd_gpr_wdata,
    output logic [11:0]              rd_csr_waddr,
    output logic [XLEN-1:0]          rd_csr_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halt_req,
    output logic [1:0]               halt_cause,
    input  logic                     resume
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = 4 + XLEN + 32 + 5 + XLEN + 12 + XLEN;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_halt_req;
    logic [1:0]       r_halt_cause;
    logic [REC_W-1:0] r_mem [DEPTH];

    logic             w_capture;
    logic             w_full;
    logic             w_pop;
    logic             w_write;
    logic             w_overwrite;
    logic             w_drop;
    logic             w_rd_adv;
    logic             w_inc;
    logic             w_dec;
    logic             w_halt_ev;
    logic [REC_W-1:0] w_rec;
    logic [REC_W-1:0] w_rd_rec;

    // A commit only counts while running; in HALT the core is stalled so commit_valid is noise.
    assign w_capture   = commit_valid && (r_state == ST_RUN);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = (r_count != '0) && rd_ready;
    // A full buffer still accepts a commit if the same cycle pops, or if oldest-overwrite is enabled.
    assign w_write     = w_capture && (!w_full || w_pop || (WRAP_MODE != 0));
    assign w_overwrite = w_capture && w_full && !w_pop && (WRAP_MODE != 0);
    assign w_drop      = w_capture && w_full && !w_pop && (WRAP_MODE == 0);
    assign w_rd_adv    = w_pop || w_overwrite;
    assign w_inc       = w_write && !w_pop && !w_overwrite;
    assign w_dec       = w_pop && !w_write;
    // Halt fires on the commit even if its record was dropped for lack of space.
    assign w_halt_ev   = w_capture && (commit_ivd || ((HALT_ON_BRK != 0) && commit_brk));

    assign w_rec = {commit_ivd, commit_brk, csr_wen, gpr_wen, commit_pc, commit_inst,
                    gpr_waddr, gpr_wdata, csr_waddr, csr_wdata};

    assign w_rd_rec = r_mem[r_rd_ptr];
    assign {rd_flags, rd_pc, rd_inst, rd_gpr_waddr, rd_gpr_wdata,
            rd_csr_waddr, rd_csr_wdata} = w_rd_rec;

    assign rd_valid   = (r_count != '0);
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign halt_req   = r_halt_req;
    assign halt_cause = r_halt_cause;

    // Record storage: written at wr_ptr, never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset && w_write) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    // Pointers, occupancy and sticky loss flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_inc) begin
                r_count <= r_count + CW'(1);
            end else if (w_dec) begin
                r_count <= r_count - CW'(1);
            end
            if (w_overwrite || w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // RUN/HALT control with registered stall request and cause (ivd outranks brk).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_halt_req   <= 1'b0;
            r_halt_cause <= 2'b00;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_halt_ev) begin
                        r_state      <= ST_HALT;
                        r_halt_req   <= 1'b1;
                        r_halt_cause <= commit_ivd ? 2'b10 : 2'b01;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        r_state      <= ST_RUN;
                        r_halt_req   <= 1'b0;
                        r_halt_cause <= 2'b00;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_halt_req   <= 1'b0;
                    r_halt_cause <= 2'b00;
                end
            endcase
        end
    end

endmodule
